// File: rtl/ysyx_25040129_lsu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_lsu_pkg
// Shared definitions for the load/store sequencer:
//   - RISC-V opcode constants for LOAD / STORE
//   - funct3 width/sign selectors
//   - 2-bit FSM state encoding
//   - helper that tells whether an opcode/funct3 pair is a legal memory op
// ----------------------------------------------------------------------------
package ysyx_25040129_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Loads accept all five widths; stores have no unsigned variants.
    function automatic logic f3_legal(input logic [6:0] opcode, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (opcode == OP_LOAD) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end else if (opcode == OP_STORE) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_lsu_align
// Purely combinational byte-lane helper.
//   ea_lo     : low two bits of the effective address
//   funct3    : width/sign selector
//   src2      : store data (register value)
//   rdata     : raw 32-bit word returned by memory
//   wstrb     : byte enables for a store of this width at this offset
//   wdata     : store data replicated across all lanes
//   ext_rdata : load data shifted down to bit 0 and sign/zero extended
//   misalign  : halfword on an odd address or word not on a 4-byte boundary
// Unknown funct3 values produce all-zero outputs; legality is judged by the
// caller.
// ----------------------------------------------------------------------------
module ysyx_25040129_lsu_align
    import ysyx_25040129_lsu_pkg::*;
(
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] src2,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ext_rdata,
    output logic        misalign
);

    logic [31:0] sh;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        sh        = rdata >> {ea_lo, 3'b000};
        wstrb     = 4'b0000;
        wdata     = 32'h0;
        ext_rdata = 32'h0;
        misalign  = 1'b0;
        case (funct3)
            F3_B: begin
                wstrb     = 4'b0001 << ea_lo;
                wdata     = {4{src2[7:0]}};
                ext_rdata = {{24{sh[7]}}, sh[7:0]};
            end
            F3_H: begin
                wstrb     = ea_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{src2[15:0]}};
                ext_rdata = {{16{sh[15]}}, sh[15:0]};
                misalign  = ea_lo[0];
            end
            F3_W: begin
                wstrb     = 4'b1111;
                wdata     = src2;
                // A legal word access is aligned, so sh is the raw word.
                ext_rdata = sh;
                misalign  = |ea_lo;
            end
            F3_BU: begin
                ext_rdata = {24'h0, sh[7:0]};
            end
            F3_HU: begin
                ext_rdata = {16'h0, sh[15:0]};
                misalign  = ea_lo[0];
            end
            default: begin
                wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_lsu_ctrl
// Multi-cycle load/store sequencer between EXU and a handshaked data memory.
// One instruction per transaction: IDLE -> (REQ -> RSP ->) DONE -> IDLE.
//   in_*        : EXU offer (valid/ready), opcode, funct3, imm, src1, src2
//   out_*       : result to WBU (valid/ready), extended load data, error flag
//   mem_req_*   : request channel (valid/ready), word address, wen, wdata,
//                 wstrb
//   mem_rsp_*   : response channel (valid/ready), raw word, bus error
// Parameters:
//   TIMEOUT     : cycles allowed in REQ+RSP before a forced error (0 = off)
//   CNT_W       : timeout counter width, 2**CNT_W > TIMEOUT
// All outputs are decodes of state or plain registers, so nothing on in_* or
// mem_rsp_* reaches out_* combinationally.
// ----------------------------------------------------------------------------
module ysyx_25040129_lsu_ctrl
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,

    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err
);

    localparam bit              TO_EN   = (TIMEOUT != 0);
    // The counter holds the number of REQ/RSP cycles already spent, so the
    // TIMEOUT-th cycle is the one in which it reads TIMEOUT-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [31:0]      ea_q, ea_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             wen_q, wen_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] ea_new;
    logic        is_load, is_store, is_mem, legal, idle;
    logic        timeout_hit;

    logic [1:0]  al_ea_lo;
    logic [2:0]  al_funct3;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ext;
    logic        al_misalign;

    assign idle     = (state_q == ST_IDLE);
    assign ea_new   = in_src1 + in_imm;
    assign is_load  = (in_opcode == OP_LOAD);
    assign is_store = (in_opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign legal    = f3_legal(in_opcode, in_funct3);

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // One lane helper serves both phases: in IDLE it looks at the incoming
    // instruction (alignment, store lanes), afterwards at the latched one
    // (load extraction of the returning word).
    assign al_ea_lo  = idle ? ea_new[1:0] : ea_q[1:0];
    assign al_funct3 = idle ? in_funct3   : funct3_q;

    ysyx_25040129_lsu_align u_align (
        .ea_lo     (al_ea_lo),
        .funct3    (al_funct3),
        .src2      (in_src2),
        .rdata     (mem_rsp_rdata),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .ext_rdata (al_ext),
        .misalign  (al_misalign)
    );

    always_comb begin
        state_d  = state_q;
        ea_d     = ea_q;
        funct3_d = funct3_q;
        wen_d    = wen_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ea_d     = ea_new;
                    funct3_d = in_funct3;
                    wen_d    = is_store;
                    wstrb_d  = is_store ? al_wstrb : 4'b0000;
                    wdata_d  = is_store ? al_wdata : 32'h0;
                    rdata_d  = 32'h0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    if (!is_mem) begin
                        state_d = ST_DONE;
                    end else if (!legal || al_misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = ST_DONE;
                end else if (mem_req_ready) begin
                    state_d = ST_RSP;
                end
            end

            ST_RSP: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the expiry cycle still counts as on time.
                if (mem_rsp_valid) begin
                    err_d   = mem_rsp_err;
                    rdata_d = (mem_rsp_err || wen_q) ? 32'h0 : al_ext;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ea_q     <= 32'h0;
            funct3_q <= 3'b000;
            wen_q    <= 1'b0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ea_q     <= ea_d;
            funct3_q <= funct3_d;
            wen_q    <= wen_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready      = idle;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_rsp_ready = (state_q == ST_RSP);
    assign out_valid     = (state_q == ST_DONE);

    assign mem_req_addr  = {ea_q[31:2], 2'b00};
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

    assign out_rdata     = rdata_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25040129_lsu_ctrl
// Self-checking bench for the load/store sequencer. A memory responder
// answers requests after a configurable number of cycles; a reference model
// derives the expected address, lanes, result, error and latency from the
// instruction using plain arithmetic.
// ----------------------------------------------------------------------------
module tb_ysyx_25040129_lsu_ctrl;

    localparam int         TO     = 8;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder configuration and observations.
    int          cfg_req_wait = 0;
    int          cfg_rsp_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_err = 1'b0;
    int          rq_cnt = 0;
    int          rs_cnt = 0;
    int          req_hs = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        cap_wen = 1'b0;
    bit          req_unstable = 1'b0;

    ysyx_25040129_lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_imm        (in_imm),
        .in_src1       (in_src1),
        .in_src2       (in_src2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_err       (out_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: accepts a request after cfg_req_wait stall cycles and
    // answers cfg_rsp_wait cycles after the response phase opens.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid) begin
                if (rq_cnt == 0) begin
                    cap_addr  = mem_req_addr;
                    cap_wen   = mem_req_wen;
                    cap_wdata = mem_req_wdata;
                    cap_wstrb = mem_req_wstrb;
                end else if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} !==
                             {cap_addr, cap_wen, cap_wdata, cap_wstrb}) begin
                    req_unstable = 1'b1;
                end
                mem_req_ready = (rq_cnt == cfg_req_wait);
                if (mem_req_ready) req_hs++;
                rq_cnt++;
            end else begin
                rq_cnt        = 0;
                mem_req_ready = 1'b0;
            end
            if (mem_rsp_ready) begin
                mem_rsp_valid = (rs_cnt == cfg_rsp_wait);
                mem_rsp_rdata = cfg_rdata;
                mem_rsp_err   = mem_rsp_valid && cfg_err;
                rs_cnt++;
            end else begin
                rs_cnt        = 0;
                mem_rsp_valid = 1'b0;
                mem_rsp_err   = 1'b0;
            end
        end
    end

    // One full transaction with model-predicted results. Called at posedge+1
    // with the DUT expected to be idle.
    task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] src1, input logic [31:0] imm,
                           input logic [31:0] src2, input logic [31:0] rdata,
                           input logic rerr, input int rqw, input int rsw, input int ow);
        logic [31:0] ea, e_rdata, e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_err;
        logic [15:0] half;
        logic [7:0]  byte_v;
        longint      v, lim;
        int          off, size, e_lat, lat, hs0;
        bit          is_ld, is_st, legal, sgn, mis, bus, tmo;

        ea    = src1 + imm;
        off   = int'(ea[1:0]);
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        size  = 0;
        sgn   = 1'b0;
        legal = 1'b0;
        if (is_ld || is_st) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; legal = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; legal = 1'b1; end
                3'd2: begin size = 4; legal = 1'b1; end
                3'd4: begin size = 1; legal = is_ld; end
                3'd5: begin size = 2; legal = is_ld; end
                default: legal = 1'b0;
            endcase
        end
        mis   = legal && ((off % size) != 0);
        bus   = legal && !mis;
        tmo   = bus && ((rqw + rsw + 2) > TO);
        e_lat = !bus ? 1 : (tmo ? TO + 1 : rqw + rsw + 3);
        e_err = ((is_ld || is_st) && !bus) || tmo || (bus && rerr);

        e_rdata = 32'h0;
        if (is_ld && bus && !tmo && !rerr) begin
            lim = longint'(1) << (8 * size);
            v   = longint'(rdata >> (8 * off)) % lim;
            if (sgn && v >= lim / 2) v = v + (longint'(1) << 32) - lim;
            e_rdata = v[31:0];
        end
        e_wstrb = is_st ? 4'(((1 << size) - 1) << off) : 4'b0000;
        half    = src2[15:0];
        byte_v  = src2[7:0];
        e_wdata = (size == 1) ? byte_v * 32'h01010101 :
                  (size == 2) ? half * 32'h00010001 : src2;

        cfg_req_wait = rqw;
        cfg_rsp_wait = rsw;
        cfg_rdata    = rdata;
        cfg_err      = rerr;
        req_unstable = 1'b0;
        hs0          = req_hs;

        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_funct3 = f3;
        in_src1   = src1;
        in_imm    = imm;
        in_src2   = src2;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
            if (lat == 1) check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        end while (!out_valid && lat < 100);

        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " rdata"}, out_rdata, e_rdata);
        check({tag, " err"}, 32'(out_err), 32'(e_err));
        check({tag, " req count"}, 32'(req_hs - hs0), bus ? 32'd1 : 32'd0);
        if (bus) begin
            check({tag, " addr"}, cap_addr, {ea[31:2], 2'b00});
            check({tag, " wen"}, 32'(cap_wen), 32'(is_st));
            check({tag, " wstrb"}, 32'(cap_wstrb), 32'(e_wstrb));
            if (is_st) check({tag, " wdata"}, cap_wdata, e_wdata);
            check({tag, " req stable"}, 32'(req_unstable), 32'd0);
        end

        for (int i = 0; i < ow; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold rdata"}, out_rdata, e_rdata);
            check({tag, " hold err"}, 32'(out_err), 32'(e_err));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " consumed"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_rdata"}, out_rdata, 32'h0);
        check({tag, " out_err"}, 32'(out_err), 32'd0);
        check({tag, " req_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, " rsp_ready"}, 32'(mem_rsp_ready), 32'd0);
        check({tag, " req_fields"}, mem_req_addr | mem_req_wdata | 32'(mem_req_wstrb) | 32'(mem_req_wen), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int r;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn("lb_neg",   OP_LD, 3'd0, 32'h80000000, 32'd3, 32'h0, 32'h80ABCD12, 1'b0, 0, 0, 0);
        run_txn("sh_stall", OP_ST, 3'd1, 32'h80000000, 32'd6, 32'h1234BEEF, 32'h0, 1'b0, 4, 0, 0);
        run_txn("lw_mis",   OP_LD, 3'd2, 32'h80000000, 32'd2, 32'h0, 32'h12345678, 1'b0, 0, 0, 0);
        run_txn("lhu_hold", OP_LD, 3'd5, 32'h80000100, 32'd2, 32'h0, 32'hF00D1234, 1'b0, 0, 0, 5);
        run_txn("lw_tmo",   OP_LD, 3'd2, 32'h80000040, 32'd0, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1000, 0);
        run_txn("lbu_post", OP_LD, 3'd4, 32'h80000040, 32'd1, 32'h0, 32'hCAFEF00D, 1'b0, 1, 1, 0);
        run_txn("rsp_edge", OP_LD, 3'd1, 32'h80000000, 32'd2, 32'h0, 32'h8001FFFF, 1'b0, 3, 3, 0);
        run_txn("buserr",   OP_LD, 3'd2, 32'h80000000, 32'd4, 32'h0, 32'h11223344, 1'b1, 0, 1, 0);
        run_txn("alu",      OP_ALU, 3'd0, 32'h1, 32'h2, 32'h3, 32'h0, 1'b0, 0, 0, 1);
        run_txn("ld_f3bad", OP_LD, 3'd3, 32'h80000000, 32'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        run_txn("st_f3bad", OP_ST, 3'd4, 32'h80000000, 32'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        run_txn("sb_wrap",  OP_ST, 3'd0, 32'h00000003, 32'hFFFFFFFE, 32'h000000A5, 32'h0, 1'b0, 0, 2, 0);

        // Reset in the middle of the response phase.
        cfg_req_wait = 0;
        cfg_rsp_wait = 1000;
        in_valid  = 1'b1;
        in_opcode = OP_LD;
        in_funct3 = 3'd2;
        in_src1   = 32'h80000010;
        in_imm    = 32'h0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid rsp_ready", 32'(mem_rsp_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn("sw_after", OP_ST, 3'd2, 32'h80000020, 32'd4, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0, 0);

        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 5) ? OP_LD : (r < 9) ? OP_ST : OP_ALU;
            f3 = 3'($urandom_range(0, 7));
            run_txn("rand", op, f3, $urandom, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
